// File: rtl/nco_sweep_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// nco_sweep_ctrl
// Sequencer for the NCO + CORDIC datapath. It generates the NCO sample tick
// from a programmable divider and runs a stepped-frequency sweep from a start
// word to a stop word, with a programmable dwell per step. Each frequency point
// starts with an NCO reset followed by SETTLE_TICKS discarded ticks, then
// 'dwell' valid ticks.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   start_i              start sweep (sampled only while idle)
//   abort_i              abandon the sweep, back to idle next clock
//   div_i                tick period minus 1, in clocks
//   f_start_i/f_stop_i   first / last frequency word (signed)
//   f_step_i             step magnitude (unsigned)
//   chirp_i              rate word applied during dwell (signed)
//   dwell_i              ticks per step (0 behaves as 1)
//   tick_o               NCO tick
//   nco_rst_o            synchronous NCO reset, one clock per frequency point
//   nco_freq_o           NCO rate word (chirp in dwell, else 0)
//   nco_ofst_o           NCO offset word (current frequency point)
//   valid_o              NCO output sample valid this clock
//   step_idx_o           0-based index of the current frequency point
//   busy_o               high whenever not idle
//   done_o               one-clock pulse on normal completion
// -----------------------------------------------------------------------------
module nco_sweep_ctrl #(
    parameter int DIV_W        = 16,
    parameter int DWELL_W      = 16,
    parameter int SETTLE_TICKS = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [DIV_W-1:0]   div_i,
    input  logic [15:0]        f_start_i,
    input  logic [15:0]        f_stop_i,
    input  logic [15:0]        f_step_i,
    input  logic [15:0]        chirp_i,
    input  logic [DWELL_W-1:0] dwell_i,
    output logic               tick_o,
    output logic               nco_rst_o,
    output logic [15:0]        nco_freq_o,
    output logic [15:0]        nco_ofst_o,
    output logic               valid_o,
    output logic [15:0]        step_idx_o,
    output logic               busy_o,
    output logic               done_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_DWELL  = 3'd3,
        ST_STEP   = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_TICKS - 1);

    state_e               state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d, cnt_q, cnt_d;
    logic [15:0]          fstop_q, fstop_d, step_q, step_d, chirp_q, chirp_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d, dcnt_q, dcnt_d;
    logic                 up_q, up_d;
    logic [15:0]          settle_q, settle_d;
    logic [15:0]          ofst_q, ofst_d, idx_q, idx_d, freq_q, freq_d;
    logic                 tick_q, tick_d, rst_q, rst_d, valid_q, valid_d;
    logic                 busy_q, busy_d, done_q, done_d;

    // Next frequency point: cur +/- step in 18-bit signed, clamped so it can
    // never pass the stop word (and therefore can never wrap).
    function automatic logic [15:0] next_freq(input logic [15:0] cur,
                                              input logic [15:0] stop,
                                              input logic [15:0] step,
                                              input logic        up);
        logic signed [17:0] cur_x;
        logic signed [17:0] stop_x;
        logic signed [17:0] step_x;
        logic signed [17:0] sum_x;
        cur_x  = {{2{cur[15]}}, cur};
        stop_x = {{2{stop[15]}}, stop};
        step_x = {2'b00, step};
        if (up) begin
            sum_x = cur_x + step_x;
        end else begin
            sum_x = cur_x - step_x;
        end
        if (up && (sum_x > stop_x)) begin
            next_freq = stop;
        end else if (!up && (sum_x < stop_x)) begin
            next_freq = stop;
        end else begin
            next_freq = sum_x[15:0];
        end
    endfunction

    // Next-state and next-output computation for the whole sequencer.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        fstop_d  = fstop_q;
        step_d   = step_q;
        chirp_d  = chirp_q;
        dwell_d  = dwell_q;
        up_d     = up_q;
        ofst_d   = ofst_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        dcnt_d   = dcnt_q;

        // Abort beats every transition, including the final dwell tick;
        // offset and index simply hold.
        if (abort_i && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_d = ST_CLEAR;
                        div_d   = div_i;
                        fstop_d = f_stop_i;
                        step_d  = f_step_i;
                        chirp_d = chirp_i;
                        dwell_d = (dwell_i == {DWELL_W{1'b0}}) ? DWELL_W'(1) : dwell_i;
                        up_d    = ($signed(f_stop_i) >= $signed(f_start_i));
                        ofst_d  = f_start_i;
                        idx_d   = 16'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    state_d  = ST_SETTLE;
                    settle_d = 16'd0;
                end
                ST_SETTLE: begin
                    if (tick_q) begin
                        if (settle_q == SETTLE_LAST) begin
                            state_d = ST_DWELL;
                            dcnt_d  = {DWELL_W{1'b0}};
                        end else begin
                            settle_d = settle_q + 16'd1;
                        end
                    end else begin
                        settle_d = settle_q;
                    end
                end
                ST_DWELL: begin
                    if (tick_q) begin
                        if (dcnt_q == (dwell_q - DWELL_W'(1))) begin
                            if ((ofst_q == fstop_q) || (step_q == 16'd0)) begin
                                state_d = ST_DONE;
                            end else begin
                                state_d = ST_STEP;
                                ofst_d  = next_freq(ofst_q, fstop_q, step_q, up_q);
                                idx_d   = (idx_q == 16'hFFFF) ? idx_q : idx_q + 16'd1;
                            end
                        end else begin
                            dcnt_d = dcnt_q + DWELL_W'(1);
                        end
                    end else begin
                        dcnt_d = dcnt_q;
                    end
                end
                ST_STEP: begin
                    state_d  = ST_SETTLE;
                    settle_d = 16'd0;
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
        rst_d  = (state_d == ST_CLEAR) || (state_d == ST_STEP);
        done_d = (state_d == ST_DONE);

        // Divider restarts at every NCO restart and only runs while busy.
        if (rst_d) begin
            cnt_d = {DIV_W{1'b0}};
        end else if (busy_d) begin
            cnt_d = (cnt_q == div_d) ? {DIV_W{1'b0}} : cnt_q + DIV_W'(1);
        end else begin
            cnt_d = {DIV_W{1'b0}};
        end
        tick_d  = busy_d && (cnt_d == div_d);
        valid_d = tick_d && (state_d == ST_DWELL);

        // Rate word only during dwell; idle keeps the last value driven.
        if (state_d == ST_DWELL) begin
            freq_d = chirp_d;
        end else if (busy_d) begin
            freq_d = 16'd0;
        end else begin
            freq_d = freq_q;
        end
    end

    // State, configuration and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            div_q    <= {DIV_W{1'b0}};
            cnt_q    <= {DIV_W{1'b0}};
            fstop_q  <= 16'd0;
            step_q   <= 16'd0;
            chirp_q  <= 16'd0;
            dwell_q  <= {DWELL_W{1'b0}};
            dcnt_q   <= {DWELL_W{1'b0}};
            up_q     <= 1'b0;
            settle_q <= 16'd0;
            ofst_q   <= 16'd0;
            idx_q    <= 16'd0;
            freq_q   <= 16'd0;
            tick_q   <= 1'b0;
            rst_q    <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            fstop_q  <= fstop_d;
            step_q   <= step_d;
            chirp_q  <= chirp_d;
            dwell_q  <= dwell_d;
            dcnt_q   <= dcnt_d;
            up_q     <= up_d;
            settle_q <= settle_d;
            ofst_q   <= ofst_d;
            idx_q    <= idx_d;
            freq_q   <= freq_d;
            tick_q   <= tick_d;
            rst_q    <= rst_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign tick_o     = tick_q;
    assign nco_rst_o  = rst_q;
    assign nco_freq_o = freq_q;
    assign nco_ofst_o = ofst_q;
    assign valid_o    = valid_q;
    assign step_idx_o = idx_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
`timescale 1ns/1ps
// Bench for nco_sweep_ctrl: a timeline model expands each sweep into the
// expected per-clock output trace; every clock of a sweep is compared.
module tb_nco_sweep_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni, start_i, abort_i;
    logic [15:0] div_i, f_start_i, f_stop_i, f_step_i, chirp_i, dwell_i;
    logic        tick_o, nco_rst_o, valid_o, busy_o, done_o;
    logic [15:0] nco_freq_o, nco_ofst_o, step_idx_o;

    nco_sweep_ctrl dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
        .div_i(div_i), .f_start_i(f_start_i), .f_stop_i(f_stop_i),
        .f_step_i(f_step_i), .chirp_i(chirp_i), .dwell_i(dwell_i),
        .tick_o(tick_o), .nco_rst_o(nco_rst_o), .nco_freq_o(nco_freq_o),
        .nco_ofst_o(nco_ofst_o), .valid_o(valid_o), .step_idx_o(step_idx_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        tick, rst, valid, busy, done;
        logic [15:0] freq, ofst, idx;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] m_freq, m_ofst, m_idx;
    int          n_checks = 0;
    int          n_errors = 0;
    int          dut_ticks = 0, dut_valid = 0, dut_done = 0, dut_rst = 0;

    task automatic chk(input string nm, input int cyc, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic emit(input bit tk, input bit rs, input bit vl, input logic [15:0] fq,
                        input logic [15:0] of, input logic [15:0] ix, input bit by, input bit dn);
        exp_t e;
        e.tick = tk; e.rst = rs; e.valid = vl; e.busy = by; e.done = dn;
        e.freq = fq; e.ofst = of; e.idx = ix;
        m_freq = fq; m_ofst = of; m_idx = ix;
        exp_q.push_back(e);
    endtask

    // Timeline model: list the frequency points, then lay each point out as
    // restart clock + 16 settle ticks + D dwell ticks, ticks falling on
    // clocks where (clock-since-restart mod period) == period-1.
    task automatic gen(input int dv, input int fs, input int fe, input int st,
                       input int ch, input int dw, input int abort_at);
        int pts[$];
        int cur, nxt, per, d, n, k, cyc;
        bit up, stop, tk;
        per = dv + 1;
        d   = (dw == 0) ? 1 : dw;
        up  = (fe >= fs);
        cur = fs;
        pts.push_back(cur);
        while (!(cur == fe || st == 0)) begin
            nxt = up ? cur + st : cur - st;
            if (up ? (nxt > fe) : (nxt < fe)) nxt = fe;
            cur = nxt;
            pts.push_back(cur);
        end
        cyc = 0; stop = 0; k = 0;
        foreach (pts[p]) begin
            if (!stop) begin
                n = 0;
                for (k = 0; !stop; k++) begin
                    tk = ((k % per) == per - 1);
                    if (k == 0)      emit(tk, 1'b1, 1'b0, 16'd0, 16'(pts[p]), 16'(p), 1'b1, 1'b0);
                    else if (n < 16) emit(tk, 1'b0, 1'b0, 16'd0, 16'(pts[p]), 16'(p), 1'b1, 1'b0);
                    else             emit(tk, 1'b0, tk, 16'(ch), 16'(pts[p]), 16'(p), 1'b1, 1'b0);
                    if (k > 0 && tk) n++;
                    stop = (cyc == abort_at);
                    cyc++;
                    if (k > 0 && tk && n == 16 + d) break;
                end
            end
        end
        if (!stop) emit(((k + 1) % per) == per - 1, 1'b0, 1'b0, 16'd0, m_ofst, m_idx, 1'b1, 1'b1);
        repeat (3) emit(1'b0, 1'b0, 1'b0, m_freq, m_ofst, m_idx, 1'b0, 1'b0);
    endtask

    task automatic pin_model(input int w_ticks, input int w_valid, input int w_done, input int w_rst);
        int t, v, dn, r;
        t = 0; v = 0; dn = 0; r = 0;
        foreach (exp_q[i]) begin
            t += int'(exp_q[i].tick); v += int'(exp_q[i].valid);
            dn += int'(exp_q[i].done); r += int'(exp_q[i].rst);
        end
        chk("model_ticks", 0, t, w_ticks);
        chk("model_valid", 0, v, w_valid);
        chk("model_done", 0, dn, w_done);
        chk("model_rst", 0, r, w_rst);
    endtask

    task automatic start_sweep(input int dv, input int fs, input int fe, input int st,
                               input int ch, input int dw, input int abort_at, input bit ab);
        @(negedge clk_i);
        div_i = 16'(dv); f_start_i = 16'(fs); f_stop_i = 16'(fe); f_step_i = 16'(st);
        chirp_i = 16'(ch); dwell_i = 16'(dw); start_i = 1'b1; abort_i = ab;
        gen(dv, fs, fe, st, ch, dw, abort_at);
    endtask

    // Per-clock compare of every output against the model trace, with bounded wait.
    task automatic run(input int abort_at, input int restart_at);
        exp_t e;
        int   i;
        i = 0;
        for (int g = 0; g < 5000 && exp_q.size() > 0; g++) begin
            @(negedge clk_i);
            e = exp_q.pop_front();
            chk("tick", i, int'(tick_o), int'(e.tick));
            chk("nco_rst", i, int'(nco_rst_o), int'(e.rst));
            chk("valid", i, int'(valid_o), int'(e.valid));
            chk("busy", i, int'(busy_o), int'(e.busy));
            chk("done", i, int'(done_o), int'(e.done));
            chk("freq", i, int'(nco_freq_o), int'(e.freq));
            chk("ofst", i, int'(nco_ofst_o), int'(e.ofst));
            chk("step_idx", i, int'(step_idx_o), int'(e.idx));
            dut_ticks += int'(tick_o); dut_valid += int'(valid_o);
            dut_done  += int'(done_o); dut_rst   += int'(nco_rst_o);
            start_i = (i == restart_at);
            if (i == restart_at) f_stop_i = 16'd1000;
            abort_i = (i == abort_at);
            i++;
        end
        if (exp_q.size() > 0) begin
            n_checks++; n_errors++;
            $display("FAIL run_timeout: got %0d pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_tick"}, 0, int'(tick_o), 0);
        chk({tag, "_rst"}, 0, int'(nco_rst_o), 0);
        chk({tag, "_freq"}, 0, int'(nco_freq_o), 0);
        chk({tag, "_ofst"}, 0, int'(nco_ofst_o), 0);
        chk({tag, "_valid"}, 0, int'(valid_o), 0);
        chk({tag, "_idx"}, 0, int'(step_idx_o), 0);
        chk({tag, "_busy"}, 0, int'(busy_o), 0);
        chk({tag, "_done"}, 0, int'(done_o), 0);
    endtask

    initial begin
        int t0, v0, d0, r0;
        rst_ni = 1'b1; start_i = 1'b0; abort_i = 1'b0;
        div_i = 16'd0; f_start_i = 16'd0; f_stop_i = 16'd0; f_step_i = 16'd0;
        chirp_i = 16'd0; dwell_i = 16'd0;
        m_freq = 16'd0; m_ofst = 16'd0; m_idx = 16'd0;
        #2 rst_ni = 1'b0;
        #5 chk_zero("reset");
        @(negedge clk_i) rst_ni = 1'b1;
        @(negedge clk_i) chk_zero("after_reset");

        // Up sweep 100..400 step 100, tick every 4 clocks, dwell 4.
        t0 = dut_ticks; v0 = dut_valid; d0 = dut_done; r0 = dut_rst;
        start_sweep(3, 100, 400, 100, 0, 4, -1, 1'b0);
        pin_model(80, 16, 1, 4);
        run(-1, -1);
        chk("t1_ticks", 0, dut_ticks - t0, 80);
        chk("t1_valid", 0, dut_valid - v0, 16);
        chk("t1_done", 0, dut_done - d0, 1);
        chk("t1_rst", 0, dut_rst - r0, 4);
        chk("t1_ofst", 0, int'(nco_ofst_o), 400);
        chk("t1_idx", 0, int'(step_idx_o), 3);

        // Down sweep with clamp, chirp 5, start and abort together (start wins).
        d0 = dut_done;
        start_sweep(1, 500, -250, 300, 5, 2, -1, 1'b1);
        run(-1, -1);
        chk("t2_ofst", 0, int'(nco_ofst_o), 'hFF06);
        chk("t2_idx", 0, int'(step_idx_o), 3);
        chk("t2_done", 0, dut_done - d0, 1);
        chk("t2_freq_idle", 0, int'(nco_freq_o), 0);

        // Single point f_start==f_stop, dwell 0 behaves as 1.
        t0 = dut_ticks; v0 = dut_valid; d0 = dut_done;
        start_sweep(1, 77, 77, 50, 0, 0, -1, 1'b0);
        run(-1, -1);
        chk("t3_ticks", 0, dut_ticks - t0, 17);
        chk("t3_valid", 0, dut_valid - v0, 1);
        chk("t3_done", 0, dut_done - d0, 1);
        chk("t3_ofst", 0, int'(nco_ofst_o), 77);

        // f_step == 0 gives a single point; div 0 ticks every clock.
        v0 = dut_valid;
        start_sweep(0, 10, 90, 0, 3, 3, -1, 1'b0);
        run(-1, -1);
        chk("t4_valid", 0, dut_valid - v0, 3);
        chk("t4_ofst", 0, int'(nco_ofst_o), 10);
        chk("t4_idx", 0, int'(step_idx_o), 0);

        // Abort in the dwell of step 2 (clock 230), then a clean full rerun.
        d0 = dut_done;
        start_sweep(3, 100, 400, 100, 0, 4, 230, 1'b0);
        run(230, -1);
        chk("t5_done", 0, dut_done - d0, 0);
        chk("t5_ofst", 0, int'(nco_ofst_o), 300);
        chk("t5_idx", 0, int'(step_idx_o), 2);
        v0 = dut_valid; d0 = dut_done;
        start_sweep(3, 100, 400, 100, 0, 4, -1, 1'b0);
        run(-1, -1);
        chk("t5_rerun_valid", 0, dut_valid - v0, 16);
        chk("t5_rerun_done", 0, dut_done - d0, 1);

        // start_i with a different f_stop mid-sweep is ignored.
        v0 = dut_valid;
        start_sweep(3, 100, 400, 100, 0, 4, -1, 1'b0);
        run(-1, 50);
        chk("t6_valid", 0, dut_valid - v0, 16);
        chk("t6_ofst", 0, int'(nco_ofst_o), 400);

        // Asynchronous reset in the middle of SETTLE.
        @(negedge clk_i);
        div_i = 16'd3; f_start_i = 16'd100; f_stop_i = 16'd400; f_step_i = 16'd100;
        chirp_i = 16'd7; dwell_i = 16'd4; start_i = 1'b1;
        @(negedge clk_i) start_i = 1'b0;
        repeat (20) @(negedge clk_i);
        chk("t7_busy_before", 0, int'(busy_o), 1);
        #2 rst_ni = 1'b0;
        #1 chk_zero("t7_async");
        @(negedge clk_i) rst_ni = 1'b1;
        @(negedge clk_i) chk_zero("t7_after");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
